sisc_mc_core: RTL and testbench
===============================

# sisc_mc_core

Parametrised multicycle SISC core: the next generation of the SISC top level, folding PC, IR, register file, ALU, status register and control FSM into one block. Data width, register count and address width are generic. The core fetches 32-bit instructions and accesses data through req/ack handshake ports, so it stalls on slow memories. It also supports branches, loads/stores and a HALT state.

## Interface
- DW, 32: datapath / register width (≥16)
- NREGS, 16: register count (≤16, 4-bit fields); R0 reads 0, writes ignored
- PW, 16: instruction/data address width (word addresses)
- clk  in  1  clock, rising edge
- rst_f  in  1  asynchronous active-low reset
- im_req  out  1  instruction fetch request
- im_addr  out  PW  fetch address (= pc)
- im_data  in  32  instruction word, valid with im_ack
- im_ack  in  1  fetch complete
- dm_req  out  1  data access request
- dm_we  out  1  1 = store, 0 = load
- dm_addr  out  PW  data address
- dm_wdata  out  DW  store data
- dm_rdata  in  DW  load data, valid with dm_ack
- dm_ack  in  1  data access complete
- pc  out  PW  current PC
- stat  out  4  status {C,V,N,Z} (bit3..bit0)
- halted  out  1  core in HALT

## Operation
- IR fields: op=ir[31:28], mm=ir[27:24], rd=ir[23:20], rs=ir[19:16], rt=ir[15:12], imm=ir[15:0], sign-extended to DW.
- Opcodes: 0 NOP; 1 ALU rd←rs op rt; 2 ALU rd←rs op imm; 4 BRA; 5 BRR; 6 LOD rd←M[rs+imm]; 7 STR M[rs+imm]←R[rd]; F HALT; others execute as NOP.
- ALU op = mm: 0 add, 1 sub (rs−x), 2 and, 3 or, 4 xor, 5 not rs, 6 shl 1, 7 shr 1 (logical); mm[3]=1 is a NOP, with no write and no stat update.
- Stat is updated only by ALU ops:
  - Z = result==0; N = result[DW-1].
  - C: carry-out (add), no-borrow (sub), bit shifted out (shifts), 0 otherwise.
  - V: signed overflow for add/sub, else 0.
- BRA: taken if mm==0 or (stat & mm)≠0; pc←imm[PW-1:0]. BRR: same condition; pc←pc+sext(imm), where pc has already been incremented. PC arithmetic is modulo 2^PW.
- LOD/STR address = (R[rs]+sext(imm)) truncated to PW bits.
- Register indices ≥ NREGS read as 0; writes to them are ignored.
- FSM states:
  - FETCH: im_req=1 until im_ack; then ir←im_data, pc←pc+1, go to DECODE.
  - DECODE: read operands; HALT→HALT; NOP→FETCH; else EXEC.
  - EXEC: ALU/branch resolution. Branch→FETCH, LOD/STR→MEM, ALU→WB.
  - MEM: dm_req=1 until dm_ack; LOD→WB, STR→FETCH.
  - WB: register write, then FETCH.
  - HALT: halted=1, no requests. Exit only by reset.

## Timing
- Reset (async assert, sync deassert by user) sets pc=0, stat=0, all regs=0, state=FETCH, im_req=dm_req=0, halted=0.
- First im_req goes high on the first clk after rst_f rises.
- Req/ack handshake:
  - req and addr/data/we are held stable while req=1 and ack=0.
  - An ack sampled on a rising edge completes the transfer; req is low in the following cycle.
  - ack while req=0 is ignored.
- Latency with a zero-wait ack (ack in the same cycle as req):
  - ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch / STR: 3 / 4 cycles.
  - LOD: 5 cycles.
  - NOP: 2 cycles.
  - Each wait cycle adds 1.
- stat updates at the end of EXEC; a branch in the next instruction sees it.
- pc wraps 2^PW−1→0 without a flag.
- Reset mid-handshake drops req immediately. Memory must discard the transaction, and no register or stat write occurs.

## Structure
- Package sisc_pkg holds opcode constants, the ALU op enum, the FSM state enum and the stat bit indices (STAT_Z=0, N=1, V=2, C=3).
- Sub-module sisc_alu_p #(DW): combinational ALU producing result and the {C,V,N,Z} flags.
- Register file, PC and FSM are inline in sisc_mc_core.

## Test plan
- Program R1←R0+imm 5 (op2 mm0), R2←R1 sub imm 5 with zero-wait acks → R1=5, then R2=0, stat=4'b1001 (C=1, Z=1); the ALU instruction completes in 4 cycles.
- BRA mm=0001 after Z=1 with imm=0x0040 → next im_addr=0x0040; with Z=0 → im_addr=pc+1.
- STR R1 to [R0+0x10], then LOD R3 from [R0+0x10] with dm_ack delayed 3 cycles → dm_req held 4 cycles with stable dm_addr=0x10; R3=5 afterwards.
- Add 0x7FFFFFFF+1 (DW=32) → result 0x80000000, V=1, N=1, C=0, Z=0.
- HALT at pc=7 → halted=1, im_req stays 0 for 20 cycles; pulse rst_f low → pc=0, halted=0, regs=0.
- Assert rst_f low while im_req=1 awaiting im_ack → im_req falls asynchronously; with NREGS=8, a write to R9 leaves all registers unchanged.

Source files
------------

// File: rtl/sisc_pkg.sv
// sisc_pkg: shared definitions for the SISC multicycle core.
//   - opcode constants (ir[31:28])
//   - ALU operation enum (ir[26:24] when ir[27]=0)
//   - control FSM state enum
//   - bit positions of the {C,V,N,Z} status flags
package sisc_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_RR = 4'h1;
  localparam logic [3:0] OP_ALU_RI = 4'h2;
  localparam logic [3:0] OP_BRA    = 4'h4;
  localparam logic [3:0] OP_BRR    = 4'h5;
  localparam logic [3:0] OP_LOD    = 4'h6;
  localparam logic [3:0] OP_STR    = 4'h7;
  localparam logic [3:0] OP_HALT   = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam int unsigned STAT_Z = 0;
  localparam int unsigned STAT_N = 1;
  localparam int unsigned STAT_V = 2;
  localparam int unsigned STAT_C = 3;

endpackage

// File: rtl/sisc_alu_p.sv
// sisc_alu_p: combinational ALU of the SISC core.
//   a, b    in  DW  operands (a = rs, b = rt or sign-extended immediate)
//   op      in  3   operation
//   result  out DW  result
//   flags   out 4   {C,V,N,Z} computed from this result
module sisc_alu_p
  import sisc_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_op_e       op,
  output logic [DW-1:0] result,
  output logic [3:0]    flags
);

  logic [DW:0] sum;
  logic [DW:0] dif;
  logic        c;
  logic        v;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    dif    = {1'b0, a} - {1'b0, b};
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum[DW-1:0];
        c      = sum[DW];
        v      = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      ALU_SUB: begin
        result = dif[DW-1:0];
        c      = ~dif[DW];  // carry flag means "no borrow"
        v      = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_SHL: begin
        result = {a[DW-2:0], 1'b0};
        c      = a[DW-1];
      end
      ALU_SHR: begin
        result = {1'b0, a[DW-1:1]};
        c      = a[0];
      end
      default: result = '0;
    endcase
    flags         = '0;
    flags[STAT_C] = c;
    flags[STAT_V] = v;
    flags[STAT_N] = result[DW-1];
    flags[STAT_Z] = (result == '0);
  end

endmodule

// File: rtl/sisc_mc_core.sv
// sisc_mc_core: parametrised multicycle SISC core (PC, IR, register file,
// ALU, status register and control FSM).
//   clk, rst_f                 clock (rising) / async active-low reset
//   im_req/im_addr/im_data/im_ack  instruction fetch handshake (addr = pc)
//   dm_req/dm_we/dm_addr/dm_wdata/dm_rdata/dm_ack  data load/store handshake
//   pc      current program counter
//   stat    status flags {C,V,N,Z}
//   halted  core sits in HALT until reset
module sisc_mc_core
  import sisc_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned NREGS = 16,
  parameter int unsigned PW    = 16
) (
  input  logic          clk,
  input  logic          rst_f,
  output logic          im_req,
  output logic [PW-1:0] im_addr,
  input  logic [31:0]   im_data,
  input  logic          im_ack,
  output logic          dm_req,
  output logic          dm_we,
  output logic [PW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata,
  input  logic          dm_ack,
  output logic [PW-1:0] pc,
  output logic [3:0]    stat,
  output logic          halted
);

  state_e        state_q, state_d;
  // Low only in the first cycle after reset, so the first fetch request
  // appears on the first clock after rst_f is released.
  logic          run_q, run_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [PW-1:0] maddr_q, maddr_d;
  logic [31:0]   ir_q, ir_d;
  logic [3:0]    stat_q, stat_d;
  logic [DW-1:0] res_q, res_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];

  logic [3:0]    op, mm, rd, rs, rt;
  logic [DW-1:0] rs_val, rt_val, rd_val, imm_dw, alu_b, alu_res;
  logic [PW-1:0] imm_pw;
  logic [3:0]    alu_flags;
  alu_op_e       alu_op;
  logic          br_take;

  assign op     = ir_q[31:28];
  assign mm     = ir_q[27:24];
  assign rd     = ir_q[23:20];
  assign rs     = ir_q[19:16];
  assign rt     = ir_q[15:12];
  assign imm_dw = DW'($signed(ir_q[15:0]));
  assign imm_pw = PW'($signed(ir_q[15:0]));
  assign alu_op = alu_op_e'(mm[2:0]);
  assign alu_b  = (op == OP_ALU_RR) ? rt_val : imm_dw;
  assign br_take = (mm == 4'd0) || ((stat_q & mm) != 4'd0);

  // R0 and indices >= NREGS read as zero.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    rd_val = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (rs == 4'(i)) rs_val = regs_q[i];
      if (rt == 4'(i)) rt_val = regs_q[i];
      if (rd == 4'(i)) rd_val = regs_q[i];
    end
  end

  sisc_alu_p #(.DW(DW)) u_alu (
    .a      (rs_val),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .flags  (alu_flags)
  );

  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    pc_d    = pc_q;
    ir_d    = ir_q;
    stat_d  = stat_q;
    res_d   = res_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    regs_d  = regs_q;
    im_req  = 1'b0;
    dm_req  = 1'b0;
    dm_we   = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_FETCH: begin
        im_req = run_q;
        if (run_q && im_ack) begin
          ir_d    = im_data;
          pc_d    = pc_q + PW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_HALT: state_d = S_HALT;
          OP_NOP:  state_d = S_FETCH;
          OP_ALU_RR, OP_ALU_RI, OP_BRA, OP_BRR, OP_LOD, OP_STR:
                   state_d = S_EXEC;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXEC: begin
        case (op)
          OP_BRA, OP_BRR: begin
            // pc already points past the branch, so BRR is relative to pc+1
            if (br_take) pc_d = (op == OP_BRA) ? imm_pw : pc_q + imm_pw;
            state_d = S_FETCH;
          end
          OP_LOD, OP_STR: begin
            maddr_d = PW'(rs_val + imm_dw);
            wdata_d = rd_val;
            state_d = S_MEM;
          end
          default: begin
            if (!mm[3]) begin
              res_d  = alu_res;
              stat_d = alu_flags;
            end
            state_d = S_WB;
          end
        endcase
      end
      S_MEM: begin
        dm_req = 1'b1;
        dm_we  = (op == OP_STR);
        if (dm_ack) begin
          if (op == OP_LOD) begin
            res_d   = dm_rdata;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        if (op == OP_LOD || !mm[3]) begin
          for (int unsigned i = 1; i < NREGS; i++) begin
            if (rd == 4'(i)) regs_d[i] = res_q;
          end
        end
        state_d = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
      stat_q  <= '0;
      res_q   <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      stat_q  <= stat_d;
      res_q   <= res_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      regs_q  <= regs_d;
    end
  end

  assign im_addr  = pc_q;
  assign dm_addr  = maddr_q;
  assign dm_wdata = wdata_q;
  assign pc       = pc_q;
  assign stat     = stat_q;

endmodule

// File: tb/tb_sisc_mc_core.sv
module tb_sisc_mc_core;

  logic        clk;
  logic        rst_f;
  logic        im_req, im_ack;
  logic [15:0] im_addr;
  logic [31:0] im_data;
  logic        dm_req, dm_we, dm_ack;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic [15:0] pc;
  logic [3:0]  stat;
  logic        halted;

  sisc_mc_core #(.DW(32), .NREGS(8), .PW(16)) dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .im_req   (im_req),
    .im_addr  (im_addr),
    .im_data  (im_data),
    .im_ack   (im_ack),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .pc       (pc),
    .stat     (stat),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  delta;   // cycles since previous fetch, 0 = not checked
  } fexp_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
    logic [7:0]  len;     // cycles dm_req is high
  } dexp_t;

  fexp_t exp_fetch[$];
  dexp_t exp_dm[$];

  logic [31:0] imem [256];
  logic [31:0] dmem [256];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_fetch = 0;
  int im_wait = 0, dm_wait = 0;
  int im_cnt = 0, dm_cnt = 0, dm_len = 0;
  logic        dm_we0;
  logic [15:0] dm_addr0;
  logic [31:0] dm_wd0;
  logic        dm_stable;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] mm,
                                      input logic [3:0] rd, input logic [3:0] rs,
                                      input logic [15:0] imm);
    return {op, mm, rd, rs, imm};
  endfunction

  task automatic fe(input logic [15:0] a, input logic [7:0] d);
    exp_fetch.push_back('{addr: a, delta: d});
  endtask

  task automatic de(input logic we, input logic [15:0] a, input logic [31:0] d, input logic [7:0] l);
    exp_dm.push_back('{we: we, addr: a, data: d, len: l});
  endtask

  // Memory responders and scoreboard consumers; acks are driven on the
  // falling edge and take effect on the following rising edge.
  always @(negedge clk) begin
    fexp_t f;
    dexp_t d;
    if (!rst_f) begin
      im_ack = 1'b0; dm_ack = 1'b0;
      im_cnt = 0; dm_cnt = 0; dm_len = 0;
    end else begin
      if (im_req) begin
        if (im_cnt == im_wait) begin
          im_ack  = 1'b1;
          im_data = imem[im_addr[7:0]];
          if (exp_fetch.size() == 0) begin
            tests++; fails++;
            $error("FAIL fetch_unexpected: observed addr %0h expected no fetch", im_addr);
          end else begin
            f = exp_fetch.pop_front();
            check("fetch_addr", 64'(im_addr), 64'(f.addr));
            if (f.delta != 8'd0) check("fetch_cycles", 64'(cyc - last_fetch), 64'(f.delta));
          end
          last_fetch = cyc;
        end else begin
          im_ack  = 1'b0;
          im_data = 32'hDEAD_BEEF;
          im_cnt++;
        end
      end else begin
        im_ack  = 1'b0;
        im_data = 32'hDEAD_BEEF;
        im_cnt  = 0;
      end

      if (dm_req) begin
        if (dm_len == 0) begin
          dm_we0 = dm_we; dm_addr0 = dm_addr; dm_wd0 = dm_wdata; dm_stable = 1'b1;
        end else if (dm_we !== dm_we0 || dm_addr !== dm_addr0 || (dm_we && dm_wdata !== dm_wd0)) begin
          dm_stable = 1'b0;
        end
        dm_len++;
        if (dm_cnt == dm_wait) begin
          dm_ack   = 1'b1;
          dm_rdata = dmem[dm_addr[7:0]];
          if (dm_we) dmem[dm_addr[7:0]] = dm_wdata;
          if (exp_dm.size() == 0) begin
            tests++; fails++;
            $error("FAIL dm_unexpected: observed addr %0h we %0b expected no access", dm_addr, dm_we);
          end else begin
            d = exp_dm.pop_front();
            check("dm_we_addr", {47'h0, dm_we0, dm_addr0}, {47'h0, d.we, d.addr});
            if (d.we) check("dm_wdata", 64'(dm_wd0), 64'(d.data));
            check("dm_len_stable", {31'h0, dm_stable, 32'(dm_len)}, {31'h0, 1'b1, 32'(d.len)});
          end
        end else begin
          dm_ack   = 1'b0;
          dm_rdata = 32'hBAD0_0BAD;
          dm_cnt++;
        end
      end else begin
        dm_ack   = 1'b0;
        dm_rdata = 32'hBAD0_0BAD;
        dm_cnt   = 0;
        dm_len   = 0;
      end
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'hF000_0000;
  endtask

  task automatic load_prog_a();
    clear_imem();
    imem[8'h00] = enc(4'h2, 4'h0, 4'd1, 4'd0, 16'h0005);  // R1 = 5
    imem[8'h01] = enc(4'h2, 4'h1, 4'd2, 4'd1, 16'h0005);  // R2 = R1-5
    imem[8'h02] = enc(4'h4, 4'h1, 4'd0, 4'd0, 16'h0040);  // BRA Z -> 0x40
    imem[8'h40] = enc(4'h7, 4'h0, 4'd1, 4'd0, 16'h0010);  // STR R1
    imem[8'h41] = enc(4'h6, 4'h0, 4'd3, 4'd0, 16'h0010);  // LOD R3
    imem[8'h42] = enc(4'h7, 4'h0, 4'd3, 4'd0, 16'h0011);
    imem[8'h43] = enc(4'h7, 4'h0, 4'd2, 4'd0, 16'h0012);
    imem[8'h44] = enc(4'h1, 4'h0, 4'd4, 4'd1, 16'h3000);  // R4 = R1+R3
    imem[8'h45] = enc(4'h4, 4'h1, 4'd0, 4'd0, 16'h0080);  // BRA Z, not taken
    imem[8'h46] = enc(4'h5, 4'h0, 4'd0, 4'd0, 16'h0002);  // BRR +2
    imem[8'h49] = enc(4'h2, 4'h0, 4'd9, 4'd0, 16'h1234);  // R9 write, ignored
    imem[8'h4A] = enc(4'h2, 4'h0, 4'd5, 4'd0, 16'hFFFF);  // R5 = -1
    imem[8'h4B] = enc(4'h1, 4'h7, 4'd5, 4'd5, 16'h0000);  // R5 >>= 1
    imem[8'h4C] = enc(4'h2, 4'h0, 4'd6, 4'd0, 16'h0001);  // R6 = 1
    imem[8'h4D] = enc(4'h1, 4'h0, 4'd7, 4'd5, 16'h6000);  // R7 = R5+R6
    imem[8'h4E] = enc(4'h2, 4'h8, 4'd1, 4'd0, 16'h0000);  // mm[3]: no effect
    imem[8'h4F] = enc(4'h7, 4'h0, 4'd7, 4'd0, 16'h0013);
    imem[8'h50] = enc(4'h7, 4'h0, 4'd9, 4'd0, 16'h0014);
    imem[8'h51] = enc(4'h7, 4'h0, 4'd1, 4'd0, 16'h0015);
    imem[8'h52] = enc(4'h0, 4'h0, 4'd0, 4'd0, 16'h0000);
    imem[8'h53] = enc(4'h3, 4'h0, 4'd0, 4'd0, 16'h0000);
    fe(16'h00, 0); fe(16'h01, 4); fe(16'h02, 4); fe(16'h40, 3);
    fe(16'h41, 7); fe(16'h42, 8); fe(16'h43, 7); fe(16'h44, 7);
    fe(16'h45, 4); fe(16'h46, 3); fe(16'h49, 3); fe(16'h4A, 4);
    fe(16'h4B, 4); fe(16'h4C, 4); fe(16'h4D, 4); fe(16'h4E, 4);
    fe(16'h4F, 0); fe(16'h50, 7); fe(16'h51, 7); fe(16'h52, 7);
    fe(16'h53, 2); fe(16'h54, 2);
    de(1'b1, 16'h10, 32'd5, 4);
    de(1'b0, 16'h10, 32'd0, 4);
    de(1'b1, 16'h11, 32'd5, 4);
    de(1'b1, 16'h12, 32'd0, 4);
    de(1'b1, 16'h13, 32'h8000_0000, 4);
    de(1'b1, 16'h14, 32'd0, 4);
    de(1'b1, 16'h15, 32'd5, 4);
  endtask

  task automatic load_prog_b();
    clear_imem();
    imem[0] = enc(4'h7, 4'h0, 4'd1, 4'd0, 16'h0020);
    imem[1] = enc(4'h7, 4'h0, 4'd7, 4'd0, 16'h0021);
    imem[2] = 32'h0000_0000;
    imem[3] = 32'h0000_0000;
    imem[4] = enc(4'hE, 4'h0, 4'd1, 4'd1, 16'h0001);
    imem[5] = 32'h0000_0000;
    imem[6] = 32'h0000_0000;
    fe(16'h0, 0); fe(16'h1, 6); fe(16'h2, 6); fe(16'h3, 4);
    fe(16'h4, 4); fe(16'h5, 4); fe(16'h6, 4); fe(16'h7, 4);
    de(1'b1, 16'h20, 32'd0, 1);
    de(1'b1, 16'h21, 32'd0, 1);
  endtask

  task automatic wait_halt(input int budget, input string tag);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(halted), 64'd1);
  endtask

  task automatic quiet(input string tag);
    logic ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (im_req || dm_req || !halted) ok = 1'b0;
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    int n;
    rst_f   = 1'b0;
    im_data = 32'hDEAD_BEEF;
    dm_rdata = 32'hBAD0_0BAD;
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_im_req", 64'(im_req), 64'd0);
    check("rst_dm_req", 64'(dm_req), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_stat", 64'(stat), 64'd0);

    // Program A: ALU, branches, delayed data memory, overflow, R9 write
    load_prog_a();
    im_wait = 0;
    dm_wait = 3;
    @(negedge clk);
    rst_f = 1'b1;
    #1 check("first_req_low", 64'(im_req), 64'd0);
    @(posedge clk);
    #1;
    check("first_req_high", 64'(im_req), 64'd1);
    check("first_req_addr", 64'(im_addr), 64'd0);
    wait_halt(600, "a_halted");
    check("a_fetch_left", 64'(exp_fetch.size()), 64'd0);
    check("a_dm_left", 64'(exp_dm.size()), 64'd0);
    check("a_pc", 64'(pc), 64'h55);
    check("a_stat", 64'(stat), 64'b0110);
    quiet("a_halt_quiet");

    // Reset pulse clears pc, halted, stat and the register file
    @(negedge clk);
    #2 rst_f = 1'b0;
    #1;
    check("rst2_pc", 64'(pc), 64'd0);
    check("rst2_halted", 64'(halted), 64'd0);
    check("rst2_stat", 64'(stat), 64'd0);
    check("rst2_im_req", 64'(im_req), 64'd0);
    load_prog_b();
    im_wait = 2;
    dm_wait = 0;
    repeat (2) @(negedge clk);
    rst_f = 1'b1;
    wait_halt(400, "b_halted");
    check("b_fetch_left", 64'(exp_fetch.size()), 64'd0);
    check("b_dm_left", 64'(exp_dm.size()), 64'd0);
    check("b_pc", 64'(pc), 64'h8);
    check("b_stat", 64'(stat), 64'd0);
    quiet("b_halt_quiet");

    // Reset while a fetch is waiting for its ack
    @(negedge clk);
    rst_f = 1'b0;
    exp_fetch.delete();
    exp_dm.delete();
    im_wait = 10;
    fe(16'h0, 0);
    @(negedge clk);
    rst_f = 1'b1;
    n = 0;
    while (!im_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("c_req_seen", 64'(im_req), 64'd1);
    repeat (3) @(posedge clk);
    #3 rst_f = 1'b0;
    #1;
    check("c_req_async_drop", 64'(im_req), 64'd0);
    check("c_pc", 64'(pc), 64'd0);
    repeat (3) @(negedge clk);
    check("c_no_fetch_done", 64'(exp_fetch.size()), 64'd1);
    check("c_no_dm_req", 64'(dm_req), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
